// File: rtl/phy_tx_nlane.sv
// N-channel to N-lane PHY transmit path: round-robin arbiter into a word FIFO,
// byte-striped across lanes on symbol boundaries, each lane serialised MSB first.
module phy_tx_nlane #(
  parameter int                NUM_IN     = 2,
  parameter int                DATA_W     = 8,
  parameter int                NUM_LANES  = 2,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM   = 8'hBC
) (
  input  logic                     clk_8f,
  input  logic                     reset,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic [NUM_IN-1:0]        valid_in,
  output logic [NUM_IN-1:0]        ready_out,
  output logic [NUM_LANES-1:0]     data_outS,
  output logic [NUM_LANES-1:0]     valid_out,
  output logic                     sym_start,
  output logic                     fifo_full
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int BC_W  = $clog2(DATA_W);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sh_q [NUM_LANES];
  logic [DATA_W-1:0] sh_d [NUM_LANES];
  logic [NUM_LANES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              grant_vld;
  logic [RR_W-1:0]   grant_idx;
  logic              push;
  logic              load;
  logic [CNT_W-1:0]  n_pop;
  logic [DATA_W-1:0] wr_data;

  // Arbiter: first valid channel at or after the round-robin pointer.
  // NOTE: combinational blocks use blocking '=' so later statements see
  // earlier results; only clocked blocks use '<='.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < NUM_IN; off++) begin
      idx = (int'(rr_q) + off) % NUM_IN;
      if (!grant_vld && valid_in[idx]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(idx);
      end
    end
  end

  // ready_out is held low while reset is asserted and never looks at pops.
  assign push      = grant_vld && (count_q < CNT_W'(FIFO_DEPTH)) && reset;
  assign ready_out = push ? (NUM_IN'(1) << grant_idx) : '0;
  assign wr_data   = data_in[grant_idx*DATA_W +: DATA_W];
  assign load      = (bit_cnt_q == BC_W'(DATA_W - 1));

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    n_pop     = '0;
    rr_d      = rr_q;
    wr_ptr_d  = wr_ptr_q;
    bit_cnt_d = load ? '0 : bit_cnt_q + BC_W'(1);
    valid_d   = valid_q;
    for (int k = 0; k < NUM_LANES; k++) sh_d[k] = {sh_q[k][DATA_W-2:0], 1'b0};

    if (push) begin
      rr_d     = (grant_idx == RR_W'(NUM_IN - 1)) ? '0 : grant_idx + RR_W'(1);
      wr_ptr_d = PTR_W'((int'(wr_ptr_q) + 1) % FIFO_DEPTH);
    end

    // Load edge: stripe the oldest words onto the lowest lanes, idle the rest.
    if (load) begin
      n_pop = (count_q < CNT_W'(NUM_LANES)) ? count_q : CNT_W'(NUM_LANES);
      for (int k = 0; k < NUM_LANES; k++) begin
        if (k < int'(n_pop)) begin
          sh_d[k]    = mem_q[PTR_W'((int'(rd_ptr_q) + k) % FIFO_DEPTH)];
          valid_d[k] = 1'b1;
        end else begin
          sh_d[k]    = IDLE_SYM;
          valid_d[k] = 1'b0;
        end
      end
    end

    rd_ptr_d = PTR_W'((int'(rd_ptr_q) + int'(n_pop)) % FIFO_DEPTH);
    count_d  = count_q + CNT_W'(push) - n_pop;
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rr_q      <= '0;
      bit_cnt_q <= '0;
      valid_q   <= '0;
      for (int k = 0; k < NUM_LANES; k++) sh_q[k] <= IDLE_SYM;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rr_q      <= rr_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
      for (int k = 0; k < NUM_LANES; k++) sh_q[k] <= sh_d[k];
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only read after a push
  // wrote it, and count/pointers (which are reset) decide validity.
  always_ff @(posedge clk_8f) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) data_outS[k] = sh_q[k][DATA_W-1];
  end

  assign valid_out = valid_q;
  assign sym_start = (bit_cnt_q == '0);
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

endmodule
